// File: rtl/ofs_rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package ofs_rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    RUN
  } rst_seq_state_e;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_LOCK_FILTER = 8;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_LOSS_CNT_W  = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ofs_rst_seq_if.sv
// Lock/abort inputs and staged reset outputs of the reset sequencer.
interface ofs_rst_seq_if #(
  parameter int NUM_STAGES = ofs_rst_seq_pkg::DEF_NUM_STAGES,
  parameter int LOSS_CNT_W = ofs_rst_seq_pkg::DEF_LOSS_CNT_W
);

  logic                  pll_locked;
  logic                  soft_rst;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    output pll_locked,
    output soft_rst,
    input  stage_rst_n,
    input  seq_done,
    input  lock_loss_cnt
  );

  modport slave (
    input  pll_locked,
    input  soft_rst,
    output stage_rst_n,
    output seq_done,
    output lock_loss_cnt
  );

endinterface

// File: rtl/ofs_rst_seq_sync.sv
// Two-flop synchronizer for asynchronous status inputs; clears to 0 on reset.
module ofs_rst_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/ofs_rst_seq.sv
// Ordered subsystem reset release gated by a filtered PLL lock.
//   state     | meaning
//   WAIT_LOCK | all stages held; counting consecutive synchronized-lock cycles
//   RELEASE   | stages released one at a time, HOLD_CYCLES apart
//   RUN       | all stages released, seq_done high; outputs steady
module ofs_rst_seq
  import ofs_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int LOSS_CNT_W  = DEF_LOSS_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  ofs_rst_seq_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(LOCK_FILTER, HOLD_CYCLES)) + 1;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  rst_seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  locked_s;
  logic                  abort;

  ofs_rst_seq_sync #(.WIDTH(1)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.pll_locked),
    .sync_out (locked_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    loss_d  = loss_q;
    abort   = (state_q != WAIT_LOCK) && (!locked_s || bus.soft_rst);

    // Abort outranks any release or advance due in the same cycle.
    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
      if (!locked_s && (loss_q != '1))
        loss_d = loss_q + LOSS_CNT_W'(1);
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (!locked_s || bus.soft_rst) begin
            cnt_d = '0;
          end else if (cnt_q == FILT_LAST) begin
            state_d = RELEASE;
            stage_d = NUM_STAGES'(1);
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (idx_q < IDX_LAST) begin
              idx_d   = idx_q + IDX_W'(1);
              // Released bits form a contiguous run from bit 0, so shifting in a 1 frees bit idx+1.
              stage_d = (stage_q << 1) | NUM_STAGES'(1);
            end else begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end
  end

  assign bus.stage_rst_n   = stage_q;
  assign bus.seq_done      = done_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_ofs_rst_seq.sv
// Directed-vector bench for ofs_rst_seq with default parameters.
module tb_ofs_rst_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_n = 0;

  always #5 clk = ~clk;

  ofs_rst_seq_if #(.NUM_STAGES(4), .LOSS_CNT_W(8)) bus ();

  ofs_rst_seq #(
    .NUM_STAGES  (4),
    .LOCK_FILTER (8),
    .HOLD_CYCLES (16),
    .LOSS_CNT_W  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    edge_n += n;
  endtask

  task automatic step_to(input int e);
    if (e > edge_n) step(e - edge_n);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] stg, input logic done, input logic [7:0] loss);
    chk({tag, ".stage"}, 32'(bus.stage_rst_n), 32'(stg));
    chk({tag, ".done"},  32'(bus.seq_done),    32'(done));
    chk({tag, ".loss"},  32'(bus.lock_loss_cnt), 32'(loss));
  endtask

  // Release schedule relative to the edge after pll_locked rises: {edge, stages, done}.
  int         sched_e [5] = '{10, 26, 42, 58, 74};
  logic [3:0] sched_s [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
  logic       sched_d [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic run_schedule(input string tag, input logic [7:0] loss);
    logic [3:0] prev_s;
    logic       prev_d;
    prev_s = 4'b0000;
    prev_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_to(sched_e[i] - 1);
      chk_out($sformatf("%s.pre%0d", tag, i), prev_s, prev_d, loss);
      step(1);
      chk_out($sformatf("%s.at%0d", tag, i), sched_s[i], sched_d[i], loss);
      prev_s = sched_s[i];
      prev_d = sched_d[i];
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.soft_rst   = 1'b0;
    step(3);
    chk_out("reset", 4'b0000, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Nominal sequence
    bus.pll_locked = 1'b1;
    edge_n = 0;
    run_schedule("nom", 8'd0);

    // Lock loss in RUN
    step_to(100);
    bus.pll_locked = 1'b0;
    step(2);
    chk_out("loss.102", 4'b1111, 1'b1, 8'd0);
    step(1);
    chk_out("loss.103", 4'b0000, 1'b0, 8'd1);

    // Relock replays the sequence; soft_rst during RELEASE with idx=2
    step(2);
    bus.pll_locked = 1'b1;
    edge_n = 0;
    step_to(45);
    chk_out("relock.45", 4'b0111, 1'b0, 8'd1);
    bus.soft_rst = 1'b1;
    step(1);
    bus.soft_rst = 1'b0;
    chk_out("soft.abort", 4'b0000, 1'b0, 8'd1);
    step(7);
    chk_out("soft.re7", 4'b0000, 1'b0, 8'd1);
    step(1);
    chk_out("soft.re8", 4'b0001, 1'b0, 8'd1);
    step(64);
    chk_out("soft.done", 4'b1111, 1'b1, 8'd1);

    // Second loss, then glitch filter
    bus.pll_locked = 1'b0;
    step(3);
    chk_out("loss2", 4'b0000, 1'b0, 8'd2);
    step(3);
    bus.pll_locked = 1'b1;
    step(5);
    bus.pll_locked = 1'b0;
    step(1);
    bus.pll_locked = 1'b1;
    edge_n = 0;
    step(5);
    chk_out("glitch.5", 4'b0000, 1'b0, 8'd2);
    step(4);
    chk_out("glitch.9", 4'b0000, 1'b0, 8'd2);
    step(1);
    chk_out("glitch.10", 4'b0001, 1'b0, 8'd2);

    // Lock loss coinciding with soft_rst counts once
    bus.pll_locked = 1'b0;
    step(2);
    chk_out("coinc.pre", 4'b0001, 1'b0, 8'd2);
    bus.soft_rst = 1'b1;
    step(1);
    bus.soft_rst = 1'b0;
    chk_out("coinc", 4'b0000, 1'b0, 8'd3);

    // Drive the counter to 255
    for (int i = 0; i < 252; i++) begin
      bus.pll_locked = 1'b1;
      step(10);
      bus.pll_locked = 1'b0;
      step(3);
    end
    chk_out("sat.255", 4'b0000, 1'b0, 8'd255);
    bus.pll_locked = 1'b1;
    step(10);
    chk_out("sat.rel", 4'b0001, 1'b0, 8'd255);
    bus.pll_locked = 1'b0;
    step(3);
    chk_out("sat.loss", 4'b0000, 1'b0, 8'd255);
    bus.pll_locked = 1'b1;
    step(10);
    bus.pll_locked = 1'b0;
    step(2);
    bus.soft_rst = 1'b1;
    step(1);
    bus.soft_rst = 1'b0;
    chk_out("sat.coinc", 4'b0000, 1'b0, 8'd255);

    // Asynchronous reset mid-RELEASE
    step(3);
    bus.pll_locked = 1'b1;
    edge_n = 0;
    step(30);
    chk_out("arst.pre", 4'b0011, 1'b0, 8'd255);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst.now", 4'b0000, 1'b0, 8'd0);
    step(1);
    rst_n = 1'b1;
    edge_n = 0;
    run_schedule("arst", 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
